tea_enc_asmd: RTL
=================

TEA_ENC_ASMD -- requirements
Module: tea_enc_asmd

Interface
REQ-001 SHALL have parameter DELTA, default 32'h9E3779B9, TEA key-schedule constant.
REQ-002 SHALL have parameter ROUNDS, default 32, number of Feistel cycles; legal range 1..64.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-005 SHALL have port ena  input  1  clock enable; low freezes all internal state and outputs.
REQ-006 SHALL have port start  input  1  request to encrypt the current data/key.
REQ-007 SHALL have port data  input  64  plaintext; v0=data[63:32], v1=data[31:0].
REQ-008 SHALL have port key  input  128  key; k0=key[127:96], k1=key[95:64], k2=key[63:32], k3=key[31:0].
REQ-009 SHALL have port cipher  output  64  ciphertext; {v0,v1} after last round.
REQ-010 SHALL have port rdy  output  1  one-cycle completion pulse; cipher valid while high and after.
REQ-011 SHALL have port busy  output  1  high while a block is being encrypted.

Function
REQ-012 SHALL implement the FSM as states IDLE, ROUND, DONE; no other reachable states.
REQ-013 SHALL, in IDLE with ena=1 and start=1, latch data and key into internal registers, clear sum and round counter, and move to ROUND on that edge (the accept edge).
REQ-014 SHALL ignore start in ROUND and DONE; latched data/key are not modified by input changes after the accept edge.
REQ-015 SHALL, per enabled ROUND cycle, perform one full TEA cycle: sum'=sum+DELTA; v0'=v0+(((v1<<4)+k0)^(v1+sum')^((v1>>5)+k1)); v1'=v1+(((v0'<<4)+k2)^(v0'+sum')^((v0'>>5)+k3)).
REQ-016 SHALL use modulo-2^32 arithmetic for all additions, logical (zero-fill) right shift, and truncate shifted-out bits.
REQ-017 SHALL move ROUND->DONE on the edge completing round ROUNDS, loading cipher={v0',v1'} on that same edge.
REQ-018 SHALL assert rdy only in DONE, for exactly one enabled cycle, then move DONE->IDLE.
REQ-019 SHALL assert busy in ROUND and DONE, deassert in IDLE.
REQ-020 SHALL, with ena=1 throughout, produce rdy high in the cycle starting ROUNDS edges after the accept edge (32 for default).
REQ-021 SHALL, when ena=0, hold state, counter, sum, v0/v1, cipher, rdy and busy unchanged; latency extends by the number of disabled cycles.
REQ-022 SHALL hold cipher between completions; it changes only on the ROUND->DONE edge.
REQ-023 SHALL accept a new start on the first IDLE cycle after DONE (back-to-back throughput ROUNDS+2 cycles/block).
REQ-024 SHALL leave final sum equal to ROUNDS*DELTA mod 2^32 (32'hC6EF3720 for defaults), matching the decoder's initial sum.

Reset
REQ-025 SHALL, on rst high at any time (including mid-ROUND or DONE), immediately force IDLE, cipher=0, rdy=0, busy=0, counter=0, sum=0, latched data/key=0.
REQ-026 SHALL, after rst release, require a fresh start; no aborted block resumes or produces rdy.

Verification
REQ-027 SHALL cover: key=0, data=0, start one cycle, ena=1 -> rdy pulse exactly 32 cycles after accept edge, cipher=64'h41EA3A0A94BAA940, busy low next cycle.
REQ-028 SHALL cover: same stimulus with ena low for 5 cycles mid-ROUND -> rdy 37 cycles after accept, same cipher, outputs frozen during stall.
REQ-029 SHALL cover: start held high and data/key changed while busy -> single rdy, cipher for originally latched values, no second accept until IDLE.
REQ-030 SHALL cover: rst pulsed at round 10 -> cipher=0, rdy=0, busy=0 immediately; no rdy without new start.
REQ-031 SHALL cover: 1000 random key/data pairs back-to-back -> every cipher equals software TEA model, and feeding cipher/key to the team's TEA decoder recovers plaintext.
REQ-032 SHALL cover: start asserted in the IDLE cycle right after rdy -> accepted, rdy exactly ROUNDS+2 cycles after previous rdy.

Source files
------------

// File: rtl/tea_enc_asmd.sv
// Iterative TEA block encryptor: one full Feistel cycle (two half-rounds) per enabled clock.
// Latches plaintext/key on accept, runs ROUNDS cycles, pulses rdy for one cycle with the ciphertext.
module tea_enc_asmd #(
  parameter logic [31:0] DELTA  = 32'h9E3779B9,
  parameter int unsigned ROUNDS = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ena,
  input  logic         start,
  input  logic [63:0]  data,
  input  logic [127:0] key,
  output logic [63:0]  cipher,
  output logic         rdy,
  output logic         busy
);

  typedef enum logic [1:0] {IDLE, ROUND, DONE} state_t;

  localparam logic [6:0] LAST_RND = 7'(ROUNDS - 1);

  state_t       state_q, state_d;
  logic [6:0]   cnt_q, cnt_d;
  logic [31:0]  sum_q, sum_d;
  logic [31:0]  v0_q, v0_d;
  logic [31:0]  v1_q, v1_d;
  logic [127:0] key_q, key_d;
  logic [63:0]  cipher_q, cipher_d;

  logic [31:0] k0, k1, k2, k3;
  logic [31:0] sum_n, v0_n, v1_n;
  logic        last_rnd;

  assign k0 = key_q[127:96];
  assign k1 = key_q[95:64];
  assign k2 = key_q[63:32];
  assign k3 = key_q[31:0];

  // Second half-round consumes the freshly updated v0 in the same cycle.
  always_comb begin
    sum_n = sum_q + DELTA;
    v0_n  = v0_q + (((v1_q << 4) + k0) ^ (v1_q + sum_n) ^ ((v1_q >> 5) + k1));
    v1_n  = v1_q + (((v0_n << 4) + k2) ^ (v0_n + sum_n) ^ ((v0_n >> 5) + k3));
  end

  assign last_rnd = (cnt_q == LAST_RND);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (ena) begin
      case (state_q)
        IDLE:    if (start) state_d = ROUND;
        ROUND:   if (last_rnd) state_d = DONE;
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Output logic
  always_comb begin
    busy = (state_q != IDLE);
    rdy  = (state_q == DONE);
  end

  assign cipher = cipher_q;

  // Datapath next values
  always_comb begin
    cnt_d    = cnt_q;
    sum_d    = sum_q;
    v0_d     = v0_q;
    v1_d     = v1_q;
    key_d    = key_q;
    cipher_d = cipher_q;
    if (ena) begin
      case (state_q)
        IDLE: begin
          if (start) begin
            v0_d  = data[63:32];
            v1_d  = data[31:0];
            key_d = key;
            sum_d = '0;
            cnt_d = '0;
          end
        end
        ROUND: begin
          sum_d = sum_n;
          v0_d  = v0_n;
          v1_d  = v1_n;
          cnt_d = cnt_q + 7'd1;
          if (last_rnd) cipher_d = {v0_n, v1_n};
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q    <= '0;
      sum_q    <= '0;
      v0_q     <= '0;
      v1_q     <= '0;
      key_q    <= '0;
      cipher_q <= '0;
    end else begin
      cnt_q    <= cnt_d;
      sum_q    <= sum_d;
      v0_q     <= v0_d;
      v1_q     <= v1_d;
      key_q    <= key_d;
      cipher_q <= cipher_d;
    end
  end

endmodule
